// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: MemToReg source codes, the
// vector-packer state type and default geometry.
package wb_pkg;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_MEM  = 2'b01;
    localparam logic [1:0] MTR_SBOX = 2'b10;
    localparam logic [1:0] MTR_RSVD = 2'b11;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LANES  = 4;
    localparam int VEC_W      = DEF_DATA_W * DEF_LANES;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } vec_state_e;

    // Lane counter width; a single-lane build still needs a 1-bit counter.
    function automatic int cnt_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/wb_vec_packer.sv
// Collects consecutive vector-lane writes to one destination into a single
// packed vector-register write; a destination change discards the partial vector.
module wb_vec_packer
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 4,
    parameter int CNT_W  = cnt_w(LANES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vwe,
    input  logic [ADDR_W-1:0]         vrd,
    input  logic [DATA_W-1:0]         wdata,
    output logic                      vrf_we,
    output logic [ADDR_W-1:0]         vrf_waddr,
    output logic [LANES*DATA_W-1:0]   vrf_wdata,
    output logic [CNT_W-1:0]          lane_cnt,
    output logic                      vec_abort,
    output vec_state_e                state_dbg
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    vec_state_e                     state_q, state_d;
    logic [LANES-1:0][DATA_W-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]              vrd_q;
    logic [CNT_W-1:0]               cnt_q, slot;
    logic                           start, append, abort, complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (vwe && !complete) state_d = ST_FILL;
            ST_FILL: if (complete)         state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A lane either extends the current vector or starts a new one (from IDLE or after an abort).
    always_comb begin
        abort    = vwe && (state_q == ST_FILL) && (vrd != vrd_q);
        append   = vwe && (state_q == ST_FILL) && (vrd == vrd_q);
        start    = vwe && !append;
        slot     = start ? '0 : cnt_q;
        complete = start ? (LANES == 1) : (append && (cnt_q == LAST));
        lane_d       = lane_q;
        lane_d[slot] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q    <= '0;
            vrd_q     <= '0;
            cnt_q     <= '0;
            vrf_we    <= 1'b0;
            vrf_waddr <= '0;
            vrf_wdata <= '0;
            vec_abort <= 1'b0;
        end else begin
            vrf_we    <= complete;
            vec_abort <= abort;
            if (start) vrd_q <= vrd;
            if (start || append) begin
                lane_q <= lane_d;
                cnt_q  <= complete ? '0 : slot + 1'b1;
            end
            if (complete) begin
                vrf_waddr <= start ? vrd : vrd_q;
                vrf_wdata <= lane_d;
            end
        end
    end

    assign lane_cnt  = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: source select, registered scalar register-file write,
// forwarding tap for decode, and vector-lane packing.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 5,
    parameter int LANES  = DEF_LANES,
    parameter int CNT_W  = cnt_w(LANES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         WB_MemData,
    input  logic [DATA_W-1:0]         WB_ALUResult,
    input  logic [DATA_W-1:0]         WB_sbox,
    input  logic [ADDR_W-1:0]         WB_rd,
    input  logic [1:0]                WB_MemToReg,
    input  logic                      WB_RegWrite,
    input  logic                      WB_VRegWrite,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      vrf_we,
    output logic [ADDR_W-1:0]         vrf_waddr,
    output logic [LANES*DATA_W-1:0]   vrf_wdata,
    output logic [CNT_W-1:0]          lane_cnt,
    output logic                      vec_abort,
    output logic                      sel_err,
    output logic                      fwd_valid,
    output logic [ADDR_W-1:0]         fwd_rd,
    output logic [DATA_W-1:0]         fwd_data
);

    logic [DATA_W-1:0] wdata;
    logic              scalar_wr;
    logic              sel_hit;
    vec_state_e        vec_state;

    // The reserved code falls back to the ALU result so the write still carries defined data.
    always_comb begin
        case (WB_MemToReg)
            MTR_MEM:  wdata = WB_MemData;
            MTR_SBOX: wdata = WB_sbox;
            default:  wdata = WB_ALUResult;
        endcase
    end

    assign scalar_wr = WB_RegWrite && (WB_rd != '0);
    assign sel_hit   = (WB_MemToReg == MTR_RSVD) && (WB_RegWrite || WB_VRegWrite);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            fwd_valid <= 1'b0;
            fwd_rd    <= '0;
            fwd_data  <= '0;
            sel_err   <= 1'b0;
        end else begin
            rf_we <= scalar_wr;
            if (scalar_wr) begin
                rf_waddr  <= WB_rd;
                rf_wdata  <= wdata;
                fwd_valid <= 1'b1;
                fwd_rd    <= WB_rd;
                fwd_data  <= wdata;
            end
            if (sel_hit) sel_err <= 1'b1;
        end
    end

    wb_vec_packer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .CNT_W  (CNT_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .vwe       (WB_VRegWrite),
        .vrd       (WB_rd),
        .wdata     (wdata),
        .vrf_we    (vrf_we),
        .vrf_waddr (vrf_waddr),
        .vrf_wdata (vrf_wdata),
        .lane_cnt  (lane_cnt),
        .vec_abort (vec_abort),
        .state_dbg (vec_state)
    );

    // The packer is idle exactly when no lanes are buffered.
    a_idle_empty: assert property (@(posedge clk) disable iff (rst)
        ((vec_state == ST_IDLE) == (lane_cnt == '0)));

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a randomized run checked
// against a queue-based reference model of the writeback rules.
module tb_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LN = 4;
    localparam int CW = 2;
    localparam int VW = DW * LN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] WB_MemData = '0, WB_ALUResult = '0, WB_sbox = '0;
    logic [AW-1:0] WB_rd = '0;
    logic [1:0]    WB_MemToReg = '0;
    logic          WB_RegWrite = 1'b0, WB_VRegWrite = 1'b0;
    logic          rf_we, vrf_we, vec_abort, sel_err, fwd_valid;
    logic [AW-1:0] rf_waddr, vrf_waddr, fwd_rd;
    logic [DW-1:0] rf_wdata, fwd_data;
    logic [VW-1:0] vrf_wdata;
    logic [CW-1:0] lane_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic          m_rf_we, m_fwd_valid, m_sel_err, m_vrf_we, m_abort;
    logic [AW-1:0] m_rf_waddr, m_fwd_rd, m_vrf_waddr, buf_rd;
    logic [DW-1:0] m_rf_wdata, m_fwd_data;
    logic [VW-1:0] m_vrf_wdata;
    logic [DW-1:0] buf_q[$];
    logic [AW+VW-1:0] exp_q[$];

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .WB_MemData(WB_MemData), .WB_ALUResult(WB_ALUResult), .WB_sbox(WB_sbox),
        .WB_rd(WB_rd), .WB_MemToReg(WB_MemToReg),
        .WB_RegWrite(WB_RegWrite), .WB_VRegWrite(WB_VRegWrite),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
        .lane_cnt(lane_cnt), .vec_abort(vec_abort), .sel_err(sel_err),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    task automatic model_reset();
        m_rf_we = 0; m_rf_waddr = '0; m_rf_wdata = '0;
        m_fwd_valid = 0; m_fwd_rd = '0; m_fwd_data = '0;
        m_sel_err = 0; m_vrf_we = 0; m_abort = 0;
        m_vrf_waddr = '0; m_vrf_wdata = '0; buf_rd = '0;
        buf_q.delete();
    endtask

    task automatic model_step(input logic [1:0] sel, input logic [DW-1:0] alu, mem, sbox,
                              input logic [AW-1:0] rd, input logic rw, vw);
        logic [DW-1:0] wd;
        wd = (sel == 2'd1) ? mem : (sel == 2'd2) ? sbox : alu;
        if (sel == 2'd3 && (rw || vw)) m_sel_err = 1;
        m_rf_we = rw && (rd != 0);
        if (m_rf_we) begin
            m_rf_waddr = rd; m_rf_wdata = wd;
            m_fwd_valid = 1; m_fwd_rd = rd; m_fwd_data = wd;
        end
        m_vrf_we = 0; m_abort = 0;
        if (vw) begin
            if (buf_q.size() != 0 && rd != buf_rd) begin
                m_abort = 1;
                buf_q.delete();
            end
            if (buf_q.size() == 0) buf_rd = rd;
            buf_q.push_back(wd);
            if (buf_q.size() == LN) begin
                m_vrf_we = 1;
                m_vrf_waddr = buf_rd;
                for (int i = 0; i < LN; i++) m_vrf_wdata[i*DW +: DW] = buf_q[i];
                buf_q.delete();
            end
        end
    endtask

    function automatic logic [CW-1:0] m_lane_cnt();
        return CW'(buf_q.size());
    endfunction

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic [1:0] sel, input logic [DW-1:0] alu, mem, sbox,
                        input logic [AW-1:0] rd, input logic rw, vw);
        WB_MemToReg = sel; WB_ALUResult = alu; WB_MemData = mem; WB_sbox = sbox;
        WB_rd = rd; WB_RegWrite = rw; WB_VRegWrite = vw;
        model_step(sel, alu, mem, sbox, rd, rw, vw);
        @(posedge clk); #1;
        WB_RegWrite = 0; WB_VRegWrite = 0;
    endtask

    task automatic test_reset();
        rst = 1; model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin n_fail++; $display("FAIL reset_rf got we=%0h a=%0h d=%0h exp 0", rf_we, rf_waddr, rf_wdata); end
        n_cmp++; if (vrf_we !== 1'b0 || vrf_waddr !== '0 || vrf_wdata !== '0) begin n_fail++; $display("FAIL reset_vrf got we=%0h a=%0h d=%0h exp 0", vrf_we, vrf_waddr, vrf_wdata); end
        n_cmp++; if (lane_cnt !== '0 || vec_abort !== 1'b0 || sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_misc got cnt=%0h abort=%0h sel_err=%0h exp 0", lane_cnt, vec_abort, sel_err); end
        n_cmp++; if (fwd_valid !== 1'b0 || fwd_rd !== '0 || fwd_data !== '0) begin n_fail++; $display("FAIL reset_fwd got v=%0h rd=%0h d=%0h exp 0", fwd_valid, fwd_rd, fwd_data); end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_scalar();
        step(2'b01, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_5678, 5'd7, 1'b1, 1'b0);
        n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL scalar_we got %0h exp 1", rf_we); end
        n_cmp++; if (rf_waddr !== 5'd7) begin n_fail++; $display("FAIL scalar_waddr got %0d exp 7", rf_waddr); end
        n_cmp++; if (rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL scalar_wdata got %h exp deadbeef", rf_wdata); end
        n_cmp++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL scalar_fwd got v=%0h rd=%0d d=%h exp 1/7/deadbeef", fwd_valid, fwd_rd, fwd_data); end
        step(2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL scalar_we_drop got %0h exp 0", rf_we); end
    endtask

    task automatic test_rd_zero();
        step(2'b00, 32'h5, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we got %0h exp 0", rf_we); end
        n_cmp++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd0_fwd got v=%0h rd=%0d d=%h exp 1/7/deadbeef", fwd_valid, fwd_rd, fwd_data); end
    endtask

    task automatic test_vector_fill();
        logic [DW-1:0] vals[4];
        int pulses;
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(2'b10, $urandom, $urandom, vals[i], 5'd3, 1'b0, 1'b1);
            if (vrf_we === 1'b1) begin
                pulses++;
                n_cmp++; if (vrf_waddr !== 5'd3) begin n_fail++; $display("FAIL vec_waddr got %0d exp 3", vrf_waddr); end
                n_cmp++; if (vrf_wdata !== 128'h00000044_00000033_00000022_00000011) begin n_fail++; $display("FAIL vec_wdata got %h exp 00000044000000330000002200000011", vrf_wdata); end
            end
            if (i == 2) begin
                step(2'b10, 32'h0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0);
                n_cmp++; if (lane_cnt !== 2'd3 || vrf_we !== 1'b0) begin n_fail++; $display("FAIL vec_bubble got cnt=%0d we=%0h exp 3/0", lane_cnt, vrf_we); end
            end
        end
        step(2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        if (vrf_we === 1'b1) pulses++;
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL vec_pulses got %0d exp 1", pulses); end
        n_cmp++; if (lane_cnt !== 2'd0 || vrf_wdata !== 128'h00000044_00000033_00000022_00000011) begin n_fail++; $display("FAIL vec_hold got cnt=%0d d=%h exp 0/held vector", lane_cnt, vrf_wdata); end
    endtask

    task automatic test_abort();
        step(2'b00, 32'hA1, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1);
        step(2'b00, 32'hA2, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1);
        step(2'b00, 32'hB1, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1);
        n_cmp++; if (vec_abort !== 1'b1 || lane_cnt !== 2'd1 || vrf_we !== 1'b0) begin n_fail++; $display("FAIL abort_pulse got abort=%0h cnt=%0d we=%0h exp 1/1/0", vec_abort, lane_cnt, vrf_we); end
        step(2'b01, 32'h0, 32'hB2, 32'h0, 5'd4, 1'b0, 1'b1);
        n_cmp++; if (vec_abort !== 1'b0 || lane_cnt !== 2'd2) begin n_fail++; $display("FAIL abort_one_cycle got abort=%0h cnt=%0d exp 0/2", vec_abort, lane_cnt); end
        step(2'b10, 32'h0, 32'h0, 32'hB3, 5'd4, 1'b0, 1'b1);
        step(2'b00, 32'hB4, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1);
        n_cmp++; if (vrf_we !== 1'b1 || vrf_waddr !== 5'd4) begin n_fail++; $display("FAIL abort_done got we=%0h a=%0d exp 1/4", vrf_we, vrf_waddr); end
        n_cmp++; if (vrf_wdata !== {32'hB4, 32'hB3, 32'hB2, 32'hB1}) begin n_fail++; $display("FAIL abort_data got %h exp b4/b3/b2/b1", vrf_wdata); end
    endtask

    task automatic test_sel_err();
        step(2'b11, 32'h9, 32'h77, 32'h88, 5'd5, 1'b1, 1'b0);
        n_cmp++; if (rf_we !== 1'b1 || rf_wdata !== 32'h9) begin n_fail++; $display("FAIL sel11_data got we=%0h d=%h exp 1/9", rf_we, rf_wdata); end
        n_cmp++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL sel11_err got %0h exp 1", sel_err); end
        step(2'b01, 32'h1, 32'h2, 32'h3, 5'd6, 1'b1, 1'b0);
        step(2'b00, 32'h1, 32'h2, 32'h3, 5'd6, 1'b0, 1'b0);
        n_cmp++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL sel11_sticky got %0h exp 1", sel_err); end
        rst = 1; model_reset();
        @(posedge clk); #1;
        n_cmp++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel11_clear got %0h exp 0", sel_err); end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(2'b00, 32'hC0 + i, 32'h0, 32'h0, 5'd2, 1'b1, 1'b1);
        n_cmp++; if (lane_cnt !== 2'd3 || fwd_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got cnt=%0d fwd_v=%0h exp 3/1", lane_cnt, fwd_valid); end
        #2 rst = 1;
        model_reset();
        #1;
        n_cmp++; if (lane_cnt !== '0 || rf_we !== 1'b0 || fwd_valid !== 1'b0 || fwd_data !== '0 || vrf_we !== 1'b0 || vec_abort !== 1'b0) begin n_fail++; $display("FAIL arst_now got cnt=%0d rf_we=%0h fwd_v=%0h fwd_d=%h vrf_we=%0h abort=%0h exp all 0", lane_cnt, rf_we, fwd_valid, fwd_data, vrf_we, vec_abort); end
        @(posedge clk); #1;
        rst = 0;
        step(2'b00, 32'hD0, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1);
        n_cmp++; if (vrf_we !== 1'b0 || lane_cnt !== 2'd1 || vec_abort !== 1'b0) begin n_fail++; $display("FAIL arst_after got we=%0h cnt=%0d abort=%0h exp 0/1/0", vrf_we, lane_cnt, vec_abort); end
    endtask

    task automatic test_random();
        logic [AW-1:0] rd;
        logic [1:0]    sel;
        logic [AW+VW-1:0] got;
        rd = 5'd1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 3) rd = AW'($urandom_range(0, 3));
            sel = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step(sel, $urandom, $urandom, $urandom, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
            if (m_vrf_we) exp_q.push_back({m_vrf_waddr, m_vrf_wdata});
            n_cmp++; if (rf_we !== m_rf_we) begin n_fail++; $display("FAIL rnd_rf_we c=%0d got %0h exp %0h", c, rf_we, m_rf_we); end
            if (m_rf_we) begin
                n_cmp++; if (rf_waddr !== m_rf_waddr || rf_wdata !== m_rf_wdata) begin n_fail++; $display("FAIL rnd_rf_w c=%0d got %0d/%h exp %0d/%h", c, rf_waddr, rf_wdata, m_rf_waddr, m_rf_wdata); end
            end
            n_cmp++; if (fwd_valid !== m_fwd_valid || fwd_rd !== m_fwd_rd || fwd_data !== m_fwd_data) begin n_fail++; $display("FAIL rnd_fwd c=%0d got %0h/%0d/%h exp %0h/%0d/%h", c, fwd_valid, fwd_rd, fwd_data, m_fwd_valid, m_fwd_rd, m_fwd_data); end
            n_cmp++; if (sel_err !== m_sel_err) begin n_fail++; $display("FAIL rnd_sel_err c=%0d got %0h exp %0h", c, sel_err, m_sel_err); end
            n_cmp++; if (vrf_we !== m_vrf_we || vec_abort !== m_abort) begin n_fail++; $display("FAIL rnd_pulses c=%0d got we=%0h abort=%0h exp %0h/%0h", c, vrf_we, vec_abort, m_vrf_we, m_abort); end
            n_cmp++; if (lane_cnt !== m_lane_cnt()) begin n_fail++; $display("FAIL rnd_lane_cnt c=%0d got %0d exp %0d", c, lane_cnt, m_lane_cnt()); end
            n_cmp++; if (vrf_waddr !== m_vrf_waddr || vrf_wdata !== m_vrf_wdata) begin n_fail++; $display("FAIL rnd_vrf_out c=%0d got %0d/%h exp %0d/%h", c, vrf_waddr, vrf_wdata, m_vrf_waddr, m_vrf_wdata); end
            if (vrf_we === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_sb_unexpected c=%0d got vector to %0d exp none", c, vrf_waddr);
                end else begin
                    got = exp_q.pop_front();
                    if ({vrf_waddr, vrf_wdata} !== got) begin n_fail++; $display("FAIL rnd_sb c=%0d got %h exp %h", c, {vrf_waddr, vrf_wdata}, got); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_sb_left got %0d pending exp 0", exp_q.size()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scalar();
        test_rd_zero();
        test_vector_fill();
        test_abort();
        test_sel_err();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the MEM/WB pipeline register. Consumes its WB_* outputs each cycle.
- Selects the writeback word by WB_MemToReg and issues registered writes to the scalar register file.
- Packs successive 32-bit vector results (AES column words) into one 128-bit vector-register write.
- Provides a registered forwarding tap for the decode stage.

Parameters:
- DATA_W, 32, scalar word / vector lane width.
- ADDR_W, 5, register address width.
- LANES, 4, lanes per vector register; vector width = LANES*DATA_W.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- WB_MemData  in  DATA_W  load data from MEM/WB.
- WB_ALUResult  in  DATA_W  ALU result from MEM/WB.
- WB_sbox  in  DATA_W  S-box result from MEM/WB.
- WB_rd  in  ADDR_W  destination register.
- WB_MemToReg  in  2  source select: 00 ALU, 01 Mem, 10 sbox, 11 reserved.
- WB_RegWrite  in  1  scalar write request.
- WB_VRegWrite  in  1  vector lane write request.
- rf_we  out  1  scalar register-file write enable.
- rf_waddr  out  ADDR_W  scalar write address.
- rf_wdata  out  DATA_W  scalar write data.
- vrf_we  out  1  one-cycle pulse: full vector ready.
- vrf_waddr  out  ADDR_W  vector destination.
- vrf_wdata  out  LANES*DATA_W  packed vector; lane0 in bits [DATA_W-1:0].
- lane_cnt  out  $clog2(LANES)  lanes currently buffered.
- vec_abort  out  1  one-cycle pulse: partial vector discarded.
- sel_err  out  1  sticky: MemToReg=11 seen with a write request.
- fwd_valid  out  1  forwarding entry valid.
- fwd_rd  out  ADDR_W  forwarded register.
- fwd_data  out  DATA_W  forwarded value.

Behaviour:
- Reset: all outputs and internal state are 0; FSM goes to IDLE. Assertion mid-fill discards buffered lanes, with no vec_abort pulse.
- Select (combinational): wdata = ALU / Mem / sbox for 00 / 01 / 10. Code 11 returns ALUResult and, if RegWrite or VRegWrite is set, sets sel_err (cleared only by rst).
- Scalar path, 1-cycle latency:
  - If RegWrite=1 and rd!=0, then on the next edge rf_we=1, rf_waddr=rd, rf_wdata=wdata; otherwise rf_we=0.
  - A write to rd=0 is suppressed and produces no forwarding update.
- Forwarding: on each scalar write, fwd_valid<=1, fwd_rd<=rd, fwd_data<=wdata. The entry holds until the next scalar write.
- Vector FSM, states IDLE and FILL:
  - IDLE + VRegWrite: lane[0]<=wdata, vrd<=rd, lane_cnt<=1, go to FILL.
  - FILL + VRegWrite with rd==vrd: lane[lane_cnt]<=wdata, lane_cnt++.
  - If that was lane LANES-1: on the same edge vrf_we<=1, vrf_waddr<=vrd, vrf_wdata<=all lanes including the new one; lane_cnt<=0; go to IDLE.
  - FILL + VRegWrite with rd!=vrd: vec_abort pulse; restart with lane[0]<=wdata, vrd<=rd, lane_cnt<=1; stay in FILL.
  - FILL without VRegWrite (bubble): hold all state. No timeout.
  - vrf_we and vec_abort are high for exactly one cycle.
  - vrf_wdata holds its last value when vrf_we=0.
- Combined requests: RegWrite and VRegWrite in the same cycle are both honoured independently with the same wdata.
- LANES=1: every VRegWrite produces vrf_we the next cycle; FILL is never entered.
- Throughput: one scalar write and one lane per cycle. A new vector may start the cycle after vrf_we.

Decomposition:
- Package wb_pkg: MemToReg encodings (MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_SBOX=2'b10), FSM state enum (ST_IDLE, ST_FILL), VEC_W constant.
- One sub-module, wb_vec_packer: the vector FSM, lane buffer and abort logic. The select mux, scalar path and forwarding stay in the top module.

Test Plan:
- Reset then MemToReg=01, MemData=0xDEADBEEF, rd=7, RegWrite=1 -> next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF; fwd_rd=7, fwd_data=0xDEADBEEF.
- RegWrite=1, rd=0, ALUResult=0x5 -> rf_we stays 0; fwd_valid unchanged.
- Four VRegWrite cycles, rd=3, sbox=0x11,0x22,0x33,0x44, MemToReg=10, with one bubble after lane 2 -> single vrf_we pulse; vrf_waddr=3; vrf_wdata=0x00000044_00000033_00000022_00000011.
- Two lanes to rd=3, then VRegWrite rd=4 -> vec_abort pulse; lane_cnt=1; next three lanes to rd=4 -> vrf_waddr=4 with the new data only.
- MemToReg=11, RegWrite=1, ALUResult=0x9 -> rf_wdata=0x9; sel_err=1 and remains 1 until rst.
- Three lanes buffered, assert rst asynchronously -> lane_cnt=0 and all outputs 0 immediately; after release, one lane produces no vrf_we.
